// File: rtl/clk_reset_seq_pkg.sv
// Shared definitions for the clock/reset sequencer: FSM encodings and widths.
// Pure declarations; no logic, no latency, no flow control.
package clk_rst_defs;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;

  // Cycle counter must index up to the larger of the two intervals, never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clk_reset_seq_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, resets to 0.
// Latency 2 cycles; no flow control.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clk_reset_seq.sv
// Debounces PLL lock, holds system reset for a fixed interval, then runs a periodic tick.
// Lock to release: 2 + LOCK_CYCLES + HOLD_CYCLES cycles; no backpressure, outputs are free-running.
module clk_reset_seq
  import clk_rst_defs::*;
#(
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16,
  parameter int TICK_DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  output logic                  sys_rst_n,
  output logic                  ready,
  output logic [1:0]            state,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic                  tick
);

  localparam int CNT_W  = cnt_width(LOCK_CYCLES, HOLD_CYCLES);
  localparam int TICK_W = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic                  w_lock_s;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_loss_inc;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;
  logic                  r_sys_rst_n;
  logic [TICK_W-1:0]     r_tick_cnt;
  logic [TICK_W-1:0]     w_tick_cnt_nxt;

  sync_2ff u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter defaults to 0 so every state change leaves it cleared for the next phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_loss_inc  = 1'b0;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // Lock loss takes priority over a simultaneous software request.
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_loss_inc  = 1'b1;
        end else if (sw_reset_req) begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
      end
    endcase
  end

  always_comb begin
    w_tick_cnt_nxt = '0;
    if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
      w_tick_cnt_nxt = (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sys_rst_n <= 1'b0;
      r_tick_cnt  <= '0;
      r_loss_cnt  <= '0;
    end else begin
      r_sys_rst_n <= (w_state_nxt == ST_RUN);
      r_tick_cnt  <= w_tick_cnt_nxt;
      if (w_loss_inc && (r_loss_cnt != '1)) begin
        r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
      end
    end
  end

  assign sys_rst_n  = r_sys_rst_n;
  assign ready      = r_sys_rst_n;
  assign state      = r_state;
  assign loss_count = r_loss_cnt;
  assign tick       = (r_state == ST_RUN) && (r_tick_cnt == TICK_LAST);

endmodule

// File: tb/tb_clk_reset_seq.sv
// Directed bench for clk_reset_seq with a phase-duration reference model and literal spot checks.
module tb_clk_reset_seq;

  localparam int LC = 8;
  localparam int HC = 4;
  localparam int TD = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       sys_rst_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] loss_count;
  logic       tick;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  clk_reset_seq #(
    .LOCK_CYCLES (LC),
    .HOLD_CYCLES (HC),
    .TICK_DIV    (TD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .sw_reset_req (sw_reset_req),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .state        (state),
    .loss_count   (loss_count),
    .tick         (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: lock seen two edges late, phases measured by cycles spent in them,
  // tick derived from the number of cycles elapsed since RUN was entered.
  int m_st  = 0;
  int m_age = 0;
  int m_loss = 0;
  int m_run = 0;
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;
  bit m_ls;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_age = 0; m_loss = 0; m_run = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      m_ls = m_s2;
      m_s2 = m_s1;
      m_s1 = pll_locked;
      case (m_st)
        0: if (m_ls) begin m_st = 1; m_age = 0; end
        1: if (!m_ls) m_st = 0;
           else begin
             m_age++;
             if (m_age == LC) begin m_st = 2; m_age = 0; end
           end
        2: if (!m_ls) m_st = 0;
           else begin
             m_age++;
             if (m_age == HC) begin m_st = 3; m_run = 0; end
           end
        default: if (!m_ls) begin
                   m_st = 0;
                   if (m_loss < 255) m_loss++;
                 end else if (sw_reset_req) begin
                   m_st = 2; m_age = 0;
                 end else m_run++;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_sys_rst_n", 32'(sys_rst_n), 32'(m_st == 3));
      chk("m_ready", 32'(ready), 32'(m_st == 3));
      chk("m_state", 32'(state), 32'(m_st));
      chk("m_loss_count", 32'(loss_count), 32'(m_loss));
      chk("m_tick", 32'(tick), 32'((m_st == 3) && ((m_run % TD) == TD - 1)));
    end
  end

  task automatic nedges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_st(input int s, input int lim, input string nm);
    int k = 0;
    while ((32'(state) != s) && (k < lim)) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(state), s);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int low;
    int cnt;
    rst_n = 1'b0;
    pll_locked = 1'b1;
    sw_reset_req = 1'b0;
    nedges(3);
    cmp_en = 1'b1;
    chk("rst_state", 32'(state), 0);
    chk("rst_sys_rst_n", 32'(sys_rst_n), 0);
    chk("rst_loss", 32'(loss_count), 0);
    chk("rst_tick", 32'(tick), 0);

    // Power-up: release before edge 0 with lock already high.
    rst_n = 1'b1;
    nedges(14);
    chk("pwrup_low_after_e13", 32'(sys_rst_n), 0);
    nedges(1);
    chk("pwrup_high_after_e14", 32'(sys_rst_n), 1);
    chk("pwrup_state_run", 32'(state), 3);

    for (int c = 0; c < 16; c++) begin
      chk("tick_run_cycle", 32'(tick), 32'((c == 4) || (c == 9) || (c == 14)));
      nedges(1);
    end

    sw_reset_req = 1'b1;
    nedges(1);
    sw_reset_req = 1'b0;
    low = 0;
    while (!sys_rst_n && (low < 20)) begin
      low++;
      nedges(1);
    end
    chk("sw_low_cycles", 32'(low), 4);
    chk("sw_loss_unchanged", 32'(loss_count), 0);

    pll_locked = 1'b0;
    nedges(1);
    chk("loss_after_m", 32'(sys_rst_n), 1);
    nedges(1);
    chk("loss_after_m1", 32'(sys_rst_n), 1);
    nedges(1);
    chk("loss_after_m2", 32'(sys_rst_n), 0);
    chk("loss_state", 32'(state), 0);
    chk("loss_count1", 32'(loss_count), 1);
    for (int c = 0; c < 8; c++) begin
      chk("tick_after_loss", 32'(tick), 0);
      nedges(1);
    end

    sw_reset_req = 1'b1;
    nedges(1);
    sw_reset_req = 1'b0;
    nedges(2);
    chk("sw_in_wait_state", 32'(state), 0);
    chk("sw_in_wait_loss", 32'(loss_count), 1);

    pll_locked = 1'b1;
    wait_st(3, 40, "simul_reach_run");
    nedges(2);
    pll_locked = 1'b0;
    nedges(2);
    sw_reset_req = 1'b1;
    nedges(1);
    sw_reset_req = 1'b0;
    chk("simul_state", 32'(state), 0);
    chk("simul_loss", 32'(loss_count), 2);

    pll_locked = 1'b1;
    wait_st(1, 10, "deb_enter_stable");
    nedges(5);
    pll_locked = 1'b0;
    nedges(1);
    pll_locked = 1'b1;
    wait_st(0, 10, "deb_back_to_wait");
    chk("deb_loss_unchanged", 32'(loss_count), 2);
    wait_st(1, 10, "deb_restable");
    cnt = 0;
    while (!sys_rst_n && (cnt < 40)) begin
      cnt++;
      nedges(1);
    end
    chk("deb_full_sequence", 32'(cnt), 12);

    for (int i = 0; i < 300; i++) begin
      wait_st(3, 40, "sat_run");
      pll_locked = 1'b0;
      wait_st(0, 10, "sat_wait");
      pll_locked = 1'b1;
    end
    chk("sat_loss_255", 32'(loss_count), 255);

    wait_st(3, 40, "final_run");
    nedges(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sys_rst_n", 32'(sys_rst_n), 0);
    chk("arst_ready", 32'(ready), 0);
    chk("arst_state", 32'(state), 0);
    chk("arst_loss", 32'(loss_count), 0);
    chk("arst_tick", 32'(tick), 0);
    nedges(2);
    rst_n = 1'b1;
    nedges(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
